// File: rtl/ldpc_pkg.sv
// Shared constants, state encoding and lane magnitude helper for the
// LDPC check-node min-sum unit.
package ldpc_pkg;

    localparam int Q       = 8;
    localparam int SIMD    = 8;
    localparam int MAX_DEG = 16;
    localparam int SAT     = 63;
    localparam int DW      = Q * SIMD;
    localparam int CW      = $clog2(MAX_DEG);
    localparam int DEGW    = CW + 1;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        EMIT
    } cn_state_e;

    typedef logic [Q-2:0] lane_mag_t;

    localparam lane_mag_t SAT_MAG = lane_mag_t'(SAT);

    // |v| clipped to SAT; -128 negates to 0x80 which is above SAT as well.
    function automatic lane_mag_t sat_mag(input logic [Q-1:0] v);
        logic [Q-1:0] a;
        a = v[Q-1] ? (~v + 1'b1) : v;
        return (a > {1'b0, SAT_MAG}) ? SAT_MAG : a[Q-2:0];
    endfunction

endpackage

// File: rtl/ldpc_cn_lane.sv
// One SIMD lane of the check node: tracks min1/min2/argmin and the sign
// product, and forms the extrinsic message for the edge being emitted.
module ldpc_cn_lane
    import ldpc_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          upd,
    input  logic [Q-1:0]  v,
    input  logic [CW-1:0] cnt,
    input  logic [CW-1:0] e,
    input  logic          sbuf_bit,
    output logic          s,
    output logic [Q-1:0]  msg
);

    lane_mag_t     mag;
    lane_mag_t     min1;
    lane_mag_t     min2;
    lane_mag_t     m;
    logic [CW-1:0] idx;
    logic          sgn;

    assign mag = sat_mag(v);
    assign s   = v[Q-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min1 <= SAT_MAG;
            min2 <= SAT_MAG;
            idx  <= '0;
            sgn  <= 1'b0;
        end else if (clr) begin
            min1 <= SAT_MAG;
            min2 <= SAT_MAG;
            idx  <= '0;
            sgn  <= 1'b0;
        end else if (upd) begin
            // strict compares: ties leave the earliest edge as argmin
            if (mag < min1) begin
                min2 <= min1;
                min1 <= mag;
                idx  <= cnt;
            end else if (mag < min2) begin
                min2 <= mag;
            end
            sgn <= sgn ^ s;
        end
    end

    assign m   = (e == idx) ? min2 : min1;
    assign msg = (sgn ^ sbuf_bit) ? (~{1'b0, m} + 1'b1) : {1'b0, m};

endmodule

// File: rtl/ldpc_cn_minsum_unit.sv
// Check-node min-sum unit: accumulates one SIMD LLR word per edge, then
// streams back one extrinsic message word per edge.
module ldpc_cn_minsum_unit
    import ldpc_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          flush_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [DW-1:0] in_data_i,
    input  logic          in_last_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [DW-1:0] out_data_o,
    output logic          out_last_o,
    output logic          deg_err_o,
    output logic          busy_o
);

    cn_state_e       state;
    cn_state_e       state_nxt;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   e;
    logic [DEGW-1:0] deg;
    logic [SIMD-1:0] sbuf [MAX_DEG];
    logic [SIMD-1:0] s_vec;
    logic [Q-1:0]    msg [SIMD];
    logic            in_fire;
    logic            out_fire;
    logic            last_beat;
    logic            emit_done;
    logic            clr;

    assign in_ready_o  = (state != EMIT) && !flush_i;
    assign in_fire     = in_valid_i && in_ready_o;
    assign out_valid_o = (state == EMIT);
    assign out_fire    = out_valid_o && out_ready_i && !flush_i;
    assign last_beat   = in_last_i || (cnt == CW'(MAX_DEG - 1));
    assign out_last_o  = out_valid_o && ({1'b0, e} == (deg - 1'b1));
    assign emit_done   = out_fire && out_last_o;
    assign clr         = flush_i || emit_done;
    assign busy_o      = (state != IDLE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (flush_i) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE, ACCUM: if (in_fire) state_nxt = last_beat ? EMIT : ACCUM;
                EMIT:        if (emit_done) state_nxt = IDLE;
                default:     state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt       <= '0;
            e         <= '0;
            deg       <= '0;
            deg_err_o <= 1'b0;
        end else begin
            deg_err_o <= in_fire && !in_last_i && (cnt == CW'(MAX_DEG - 1));
            if (clr) begin
                cnt <= '0;
                e   <= '0;
            end else begin
                if (in_fire) begin
                    cnt <= cnt + 1'b1;
                    deg <= {1'b0, cnt} + 1'b1;
                end
                if (out_fire) e <= e + 1'b1;
            end
        end
    end

    // Only entries below deg are ever read, so the buffer needs no reset.
    always_ff @(posedge clk_i) begin
        if (in_fire) sbuf[cnt] <= s_vec;
    end

    for (genvar i = 0; i < SIMD; i++) begin : g_lane
        ldpc_cn_lane u_lane (
            .clk      (clk_i),
            .rst_n    (rst_ni),
            .clr      (clr),
            .upd      (in_fire),
            .v        (in_data_i[i*Q +: Q]),
            .cnt      (cnt),
            .e        (e),
            .sbuf_bit (sbuf[e][i]),
            .s        (s_vec[i]),
            .msg      (msg[i])
        );
        assign out_data_o[i*Q +: Q] = out_valid_o ? msg[i] : '0;
    end

endmodule

// File: tb/tb_ldpc_cn_minsum_unit.sv
// Directed self-checking bench for ldpc_cn_minsum_unit with hand-computed
// expected message words.
module tb_ldpc_cn_minsum_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_data;
    logic        out_last;
    logic        deg_err;
    logic        busy;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ldpc_cn_minsum_unit dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .in_last_i   (in_last),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_last_o  (out_last),
        .deg_err_o   (deg_err),
        .busy_o      (busy)
    );

    function automatic logic [63:0] rep(input logic [7:0] b);
        return {8{b}};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [63:0] d, input logic l);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic recv(input string tag, input logic [63:0] exp_d, input logic exp_l);
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_data"}, out_data, exp_d);
        chk({tag, "_last"}, out_last, exp_l);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic send_basic();
        send(rep(8'h05), 1'b0);
        send(rep(8'hFD), 1'b0);
        send(rep(8'h0A), 1'b0);
        chk("basic_no_early_valid", out_valid, 0);
        send(rep(8'hEC), 1'b1);
    endtask

    initial begin
        // reset state
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_deg_err", deg_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // basic: 5,-3,10,-20 -> 3,-5,3,-3
        send_basic();
        chk("basic_latency1", out_valid, 1);
        chk("basic_in_ready_emit", in_ready, 0);
        chk("basic_no_deg_err", deg_err, 0);
        recv("basic_e0", rep(8'h03), 1'b0);
        recv("basic_e1", rep(8'hFB), 1'b0);
        recv("basic_e2", rep(8'h03), 1'b0);
        recv("basic_e3", rep(8'hFD), 1'b1);
        chk("basic_idle", busy, 0);

        // backpressure: stall three cycles on edge 1
        send_basic();
        recv("bp_e0", rep(8'h03), 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_hold_data", out_data, rep(8'hFB));
            chk("bp_hold_last", out_last, 0);
            chk("bp_in_ready", in_ready, 0);
        end
        recv("bp_e1", rep(8'hFB), 1'b0);
        recv("bp_e2", rep(8'h03), 1'b0);
        recv("bp_e3", rep(8'hFD), 1'b1);

        // saturation: -128,100,70 -> 63,-63,-63
        send(rep(8'h80), 1'b0);
        send(rep(8'h64), 1'b0);
        send(rep(8'h46), 1'b1);
        recv("sat_e0", rep(8'h3F), 1'b0);
        recv("sat_e1", rep(8'hC1), 1'b0);
        recv("sat_e2", rep(8'hC1), 1'b1);

        // degree 1: -123 -> +63
        send(rep(8'h85), 1'b1);
        recv("deg1_e0", rep(8'h3F), 1'b1);
        chk("deg1_idle", busy, 0);

        // overflow: 16 beats 1..16 without last
        for (int k = 0; k < 16; k++) begin
            send(rep(8'(k + 1)), 1'b0);
            if (k < 15) chk("ovf_no_early_err", deg_err, 0);
        end
        chk("ovf_deg_err_pulse", deg_err, 1);
        chk("ovf_valid", out_valid, 1);
        @(posedge clk);
        #1;
        chk("ovf_deg_err_once", deg_err, 0);
        recv("ovf_e0", rep(8'h02), 1'b0);
        for (int k = 1; k < 15; k++) recv("ovf_mid", rep(8'h01), 1'b0);
        recv("ovf_e15", rep(8'h01), 1'b1);
        chk("ovf_idle", busy, 0);

        // flush during EMIT at e=2
        send_basic();
        recv("fl_e0", rep(8'h03), 1'b0);
        recv("fl_e1", rep(8'hFB), 1'b0);
        @(negedge clk);
        flush = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("fl_in_ready_low", in_ready, 0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        out_ready = 1'b0;
        chk("fl_out_valid", out_valid, 0);
        chk("fl_busy", busy, 0);
        chk("fl_deg_err", deg_err, 0);
        send(rep(8'h07), 1'b0);
        send(rep(8'h09), 1'b1);
        recv("fl_new_e0", rep(8'h09), 1'b0);
        recv("fl_new_e1", rep(8'h07), 1'b1);

        // reset during ACCUM
        send(rep(8'h11), 1'b0);
        send(rep(8'hF0), 1'b0);
        chk("mr_busy_before", busy, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mr_out_valid", out_valid, 0);
        chk("mr_out_data", out_data, 0);
        chk("mr_out_last", out_last, 0);
        chk("mr_busy", busy, 0);
        chk("mr_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        send(rep(8'hF6), 1'b1);
        recv("mr_after_e0", rep(8'h3F), 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
